rx_frame_checker: RTL and testbench
===================================

Name: rx_frame_checker

Overview:
- Receive-side counterpart of the UART transmit controller.
- Consumes bytes from the UART receiver, one strobe per byte, and checks them against the transmitted frame format:
  - data bytes carry their own index, starting at 0x00;
  - each data byte is followed by a space (0x20), or by CR (0x0D) then LF (0x0A) at end of row.
- Reports received-byte count, error count, pass/fail and an activity LED to system_controller and the 7-segment display.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- TIMEOUT_MS, 500, maximum inter-byte gap while busy, in ms.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- arm  input  1  start-of-capture pulse from system_controller.
- num_of_bytes  input  8  expected data-byte count; same encoding as the transmitter: 0x01, 0x20, 0x80, 0xFF.
- rx_valid  input  1  one-cycle strobe from the UART receiver: byte complete.
- rx_byte  input  8  received byte; valid only when rx_valid=1.
- busy  output  1  high while capturing.
- done  output  1  one-cycle pulse at end of capture (normal end or timeout).
- pass  output  1  1 = zero errors in last capture; held until next arm.
- byte_count  output  8  data bytes received in the current/last capture.
- error_count  output  8  mismatches; saturates at 0xFF.
- err_code  output  2  last error: 0 none, 1 data mismatch, 2 separator mismatch, 3 timeout.
- led  output  1  toggles on every accepted data byte.

Behaviour:
- Reset: synchronous, active-high. Reset clears every output (busy, done, pass, byte_count, error_count, err_code, led) and all internal counters; state = S_IDLE. Reset mid-capture aborts with no done pulse.
- Row width derived from num_of_bytes:
  - 0x01 → 1; 0x20 → 32; 0x80 → 128;
  - 0xFF → no row break (space after every byte);
  - any other value → 1.
- Total expected data bytes N = num_of_bytes.
- States (one-hot): S_IDLE, S_EXP_DATA, S_EXP_SEP, S_EXP_LF.
- S_IDLE:
  - arm=1 → clear byte_count, error_count, err_code, pass, row counter, led, timer; busy=1; go S_EXP_DATA.
  - rx_valid in S_IDLE is ignored.
  - If arm and rx_valid arrive in the same cycle, arm wins and the byte is dropped.
- S_EXP_DATA, on rx_valid:
  - expected value = byte_count (pre-increment);
  - byte_count+1, row counter+1, led toggles;
  - if rx_byte differs: error_count+1 (saturating), err_code=1;
  - the byte is accepted as data regardless, so alignment is kept; go S_EXP_SEP.
- S_EXP_SEP, on rx_valid:
  - expected = CR if row counter == row width, else space;
  - on mismatch: error_count+1, err_code=2, then proceed as if the expected byte arrived;
  - if CR was expected → S_EXP_LF;
  - else if byte_count == N → finish;
  - else → S_EXP_DATA.
- S_EXP_LF, on rx_valid:
  - expected LF; on mismatch: error_count+1, err_code=2;
  - clear row counter;
  - if byte_count == N → finish, else → S_EXP_DATA.
- Finish: next cycle done=1 for one cycle, busy=0, pass=(error_count==0), state=S_IDLE.
- Arm while busy is ignored.
- Timeout:
  - a 32-bit timer counts while busy and clears on every rx_valid;
  - when it reaches CLK_FREQ/1000*TIMEOUT_MS: error_count+1, err_code=3, pass=0, done pulse, busy=0, go S_IDLE;
  - if rx_valid arrives in the same cycle as timer expiry, the byte wins and the timer clears.
- Latency: all outputs registered; status updates one clock after the rx_valid edge.
- byte_count never exceeds N. error_count holds at 0xFF when saturated.

Decomposition:
- Package uart_link_pkg holds:
  - ASCII constants SP=0x20, CR=0x0D, LF=0x0A;
  - state encodings;
  - err_code values;
  - a row_width function (num_of_bytes → width, with 0 meaning no break) shared with the transmitter.
- One sub-module: rx_timeout_timer (clear, enable, expired; limit parameter).

Test Plan:
- num_of_bytes=0x20; arm; feed 0x00..0x1F, each followed by SP except 0x1F followed by CR LF → byte_count=0x20, error_count=0, pass=1, exactly one done pulse, led toggled 32 times (ends 0).
- num_of_bytes=0x01; arm; feed 0x00,CR,LF → done, pass=1. Then a separate run feeding 0x00,SP,LF → err_code=2, error_count=1, pass=0.
- num_of_bytes=0x20; flip data byte 5 to 0x55 → error_count=1, err_code=1, capture continues to byte_count=0x20, pass=0.
- num_of_bytes=0xFF; feed 0x00..0xFE, each followed by SP and never CR → pass=1, byte_count=0xFF.
- TIMEOUT_MS=1 (sim): arm, send 3 bytes, then stall → done after 100_000 cycles, err_code=3, byte_count=2, pass=0, busy=0.
- Boundary and reset checks:
  - arm and rx_valid in the same cycle in S_IDLE → byte dropped, next byte 0x00 accepted;
  - arm while busy → no restart;
  - reset mid-capture → all outputs 0 next cycle, no done pulse.

Source files
------------

// File: rtl/uart_link_pkg.sv
// rtl/uart_link_pkg.sv - shared UART link constants, state/error encodings and row-width helper
package uart_link_pkg;

    localparam logic [7:0] SP = 8'h20;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef enum logic [3:0] {
        S_IDLE     = 4'b0001,
        S_EXP_DATA = 4'b0010,
        S_EXP_SEP  = 4'b0100,
        S_EXP_LF   = 4'b1000
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_DATA    = 2'd1,
        ERR_SEP     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    // A width of 0 means the frame never breaks into rows.
    function automatic logic [7:0] row_width(input logic [7:0] num_of_bytes);
        case (num_of_bytes)
            8'h01:   return 8'd1;
            8'h20:   return 8'd32;
            8'h80:   return 8'd128;
            8'hFF:   return 8'd0;
            default: return 8'd1;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/rx_frame_checker_if.sv
// rtl/rx_frame_checker_if.sv - control, receive strobe and status bundle of the frame checker
interface rx_frame_checker_if;

    logic       arm;
    logic [7:0] num_of_bytes;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] byte_count;
    logic [7:0] error_count;
    logic [1:0] err_code;
    logic       led;

    modport master (
        output arm, num_of_bytes, rx_valid, rx_byte,
        input  busy, done, pass, byte_count, error_count, err_code, led
    );

    modport slave (
        input  arm, num_of_bytes, rx_valid, rx_byte,
        output busy, done, pass, byte_count, error_count, err_code, led
    );

endinterface

// File: rtl/rx_timeout_timer.sv
// rtl/rx_timeout_timer.sv - inter-byte gap timer that flags expiry once LIMIT idle cycles have elapsed
module rx_timeout_timer #(
    parameter int unsigned LIMIT = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [31:0] count;

    // Holds at LIMIT so a late disable can never wrap the counter.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != 32'(LIMIT))) begin
            count <= count + 32'd1;
        end
    end

    assign expired = enable && (count == 32'(LIMIT));

endmodule

// File: rtl/rx_frame_checker.sv
// rtl/rx_frame_checker.sv - checks received UART bytes against the index/separator frame format
module rx_frame_checker
    import uart_link_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned TIMEOUT_MS = 500
) (
    input  logic               clk,
    input  logic               reset,
    rx_frame_checker_if.slave  bus
);

    localparam int unsigned TIMEOUT_CYCLES = CLK_FREQ / 1000 * TIMEOUT_MS;

    state_t    state_q, state_d;
    err_code_t err_code_q, err_code_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       led_q, led_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [7:0] row_cnt_q, row_cnt_d;
    logic [7:0] n_q, n_d;
    logic [7:0] width_q, width_d;
    logic       finish;
    logic       timer_clear;
    logic       expired;

    assign timer_clear = bus.rx_valid || ((state_q == S_IDLE) && bus.arm);

    rx_timeout_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (busy_q),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            led_q      <= 1'b0;
            byte_cnt_q <= '0;
            err_cnt_q  <= '0;
            row_cnt_q  <= '0;
            n_q        <= '0;
            width_q    <= '0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            led_q      <= led_d;
            byte_cnt_q <= byte_cnt_d;
            err_cnt_q  <= err_cnt_d;
            row_cnt_q  <= row_cnt_d;
            n_q        <= n_d;
            width_q    <= width_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        led_d      = led_q;
        byte_cnt_d = byte_cnt_q;
        err_cnt_d  = err_cnt_q;
        row_cnt_d  = row_cnt_q;
        n_d        = n_q;
        width_d    = width_q;
        finish     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.arm) begin
                    err_code_d = ERR_NONE;
                    busy_d     = 1'b1;
                    pass_d     = 1'b0;
                    led_d      = 1'b0;
                    byte_cnt_d = '0;
                    err_cnt_d  = '0;
                    row_cnt_d  = '0;
                    n_d        = bus.num_of_bytes;
                    width_d    = row_width(bus.num_of_bytes);
                    state_d    = S_EXP_DATA;
                end
            end
            S_EXP_DATA: begin
                if (bus.rx_valid) begin
                    if (bus.rx_byte != byte_cnt_q) begin
                        err_cnt_d  = sat_inc(err_cnt_q);
                        err_code_d = ERR_DATA;
                    end
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    row_cnt_d  = row_cnt_q + 8'd1;
                    led_d      = ~led_q;
                    state_d    = S_EXP_SEP;
                end else if (expired) begin
                    err_cnt_d  = sat_inc(err_cnt_q);
                    err_code_d = ERR_TIMEOUT;
                    finish     = 1'b1;
                end
            end
            S_EXP_SEP: begin
                if (bus.rx_valid) begin
                    // A wrong separator is counted but treated as the expected one to keep alignment.
                    if (row_cnt_q == width_q) begin
                        if (bus.rx_byte != CR) begin
                            err_cnt_d  = sat_inc(err_cnt_q);
                            err_code_d = ERR_SEP;
                        end
                        state_d = S_EXP_LF;
                    end else begin
                        if (bus.rx_byte != SP) begin
                            err_cnt_d  = sat_inc(err_cnt_q);
                            err_code_d = ERR_SEP;
                        end
                        if (byte_cnt_q == n_q) begin
                            finish = 1'b1;
                        end else begin
                            state_d = S_EXP_DATA;
                        end
                    end
                end else if (expired) begin
                    err_cnt_d  = sat_inc(err_cnt_q);
                    err_code_d = ERR_TIMEOUT;
                    finish     = 1'b1;
                end
            end
            S_EXP_LF: begin
                if (bus.rx_valid) begin
                    if (bus.rx_byte != LF) begin
                        err_cnt_d  = sat_inc(err_cnt_q);
                        err_code_d = ERR_SEP;
                    end
                    row_cnt_d = '0;
                    if (byte_cnt_q == n_q) begin
                        finish = 1'b1;
                    end else begin
                        state_d = S_EXP_DATA;
                    end
                end else if (expired) begin
                    err_cnt_d  = sat_inc(err_cnt_q);
                    err_code_d = ERR_TIMEOUT;
                    finish     = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (finish) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == 8'd0) && (err_code_d != ERR_TIMEOUT);
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.byte_count  = byte_cnt_q;
    assign bus.error_count = err_cnt_q;
    assign bus.err_code    = err_code_q;
    assign bus.led         = led_q;

endmodule

// File: tb/tb_rx_frame_checker.sv
// tb/tb_rx_frame_checker.sv - self-checking bench for rx_frame_checker with a stream-level reference model
module tb_rx_frame_checker;

    localparam int unsigned CLK_FREQ   = 1_000_000;
    localparam int unsigned TIMEOUT_MS = 1;
    localparam int unsigned LIMIT      = CLK_FREQ / 1000 * TIMEOUT_MS;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] num;

    rx_frame_checker_if bus();

    rx_frame_checker #(.CLK_FREQ(CLK_FREQ), .TIMEOUT_MS(TIMEOUT_MS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    bit cmp_en   = 1'b0;

    // Reference model: the expected frame is a queue of bytes, each tagged data or separator.
    logic [7:0] m_exp[$];
    bit         m_isd[$];
    bit         m_busy, m_done, m_pass, m_led;
    logic [7:0] m_bc, m_ec;
    logic [1:0] m_code;
    int         m_idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int frame_width(input logic [7:0] n);
        case (n)
            8'h01:   return 1;
            8'h20:   return 32;
            8'h80:   return 128;
            8'hFF:   return 0;
            default: return 1;
        endcase
    endfunction

    task automatic model_err(input logic [1:0] code);
        m_ec   = (m_ec == 8'hFF) ? 8'hFF : m_ec + 8'd1;
        m_code = code;
    endtask

    task automatic model_step(input logic r, input logic a, input logic v,
                              input logic [7:0] b, input logic [7:0] n);
        logic [7:0] e;
        bit         isd;
        int         w;
        m_done = 1'b0;
        if (r) begin
            m_busy = 0; m_pass = 0; m_led = 0;
            m_bc = '0; m_ec = '0; m_code = '0; m_idle = 0;
            m_exp.delete();
            m_isd.delete();
        end else if (!m_busy) begin
            if (a) begin
                w = frame_width(n);
                m_exp.delete();
                m_isd.delete();
                for (int i = 0; i < int'(n); i++) begin
                    m_exp.push_back(8'(i));
                    m_isd.push_back(1'b1);
                    if (w != 0 && ((i + 1) % w) == 0) begin
                        m_exp.push_back(8'h0D); m_isd.push_back(1'b0);
                        m_exp.push_back(8'h0A); m_isd.push_back(1'b0);
                    end else begin
                        m_exp.push_back(8'h20); m_isd.push_back(1'b0);
                    end
                end
                m_busy = 1; m_pass = 0; m_led = 0;
                m_bc = '0; m_ec = '0; m_code = '0; m_idle = 0;
            end
        end else if (v) begin
            m_idle = 0;
            e   = m_exp.pop_front();
            isd = m_isd.pop_front();
            if (isd) begin
                m_bc  = m_bc + 8'd1;
                m_led = !m_led;
                if (b != e) model_err(2'd1);
            end else if (b != e) begin
                model_err(2'd2);
            end
            if (m_exp.size() == 0) begin
                m_busy = 0; m_done = 1; m_pass = (m_ec == 8'd0);
            end
        end else begin
            m_idle++;
            if (m_idle > int'(LIMIT)) begin
                model_err(2'd3);
                m_busy = 0; m_done = 1; m_pass = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("pass", 32'(bus.pass), 32'(m_pass));
            chk("byte_count", 32'(bus.byte_count), 32'(m_bc));
            chk("error_count", 32'(bus.error_count), 32'(m_ec));
            chk("err_code", 32'(bus.err_code), 32'(m_code));
            chk("led", 32'(bus.led), 32'(m_led));
            if (bus.done === 1'b1) done_cnt++;
        end
    end

    task automatic tick(input logic r, input logic a, input logic v, input logic [7:0] b);
        reset        = r;
        bus.arm      = a;
        bus.rx_valid = v;
        bus.rx_byte  = b;
        bus.num_of_bytes = num;
        @(posedge clk);
        model_step(r, a, v, b, num);
        @(negedge clk);
        reset        = 1'b0;
        bus.arm      = 1'b0;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b0, 1'b0, 1'b1, b);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_range(input int first, input int n, input int w,
                              input int bad_idx, input logic [7:0] bad_val);
        for (int i = first; i < n; i++) begin
            send((i == bad_idx) ? bad_val : 8'(i));
            if (w != 0 && ((i + 1) % w) == 0) begin
                send(8'h0D);
                send(8'h0A);
            end else begin
                send(8'h20);
            end
        end
    endtask

    task automatic arm_with(input logic [7:0] n);
        num = n;
        tick(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic settle();
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int d0;
        bit got;
        reset = 1'b1;
        num   = 8'h20;
        bus.arm = 1'b0; bus.rx_valid = 1'b0; bus.rx_byte = 8'h00; bus.num_of_bytes = 8'h20;
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        cmp_en = 1'b1;
        settle();
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_byte_count", 32'(bus.byte_count), 0);
        chk("reset_led", 32'(bus.led), 0);

        // Clean 32-byte frame with a single row break at the end.
        d0 = done_cnt;
        arm_with(8'h20);
        send_range(0, 32, 32, -1, 8'h00);
        settle();
        chk("f32_byte_count", 32'(bus.byte_count), 32'h20);
        chk("f32_error_count", 32'(bus.error_count), 0);
        chk("f32_pass", 32'(bus.pass), 1);
        chk("f32_led", 32'(bus.led), 0);
        chk("f32_done_pulses", 32'(done_cnt - d0), 1);

        // Single byte frame: good, then SP where CR belongs.
        arm_with(8'h01);
        send(8'h00); send(8'h0D); send(8'h0A);
        settle();
        chk("f1_pass", 32'(bus.pass), 1);
        chk("f1_byte_count", 32'(bus.byte_count), 1);
        arm_with(8'h01);
        send(8'h00); send(8'h20); send(8'h0A);
        settle();
        chk("f1sep_err_code", 32'(bus.err_code), 2);
        chk("f1sep_error_count", 32'(bus.error_count), 1);
        chk("f1sep_pass", 32'(bus.pass), 0);

        // Corrupted data byte 5.
        arm_with(8'h20);
        send_range(0, 32, 32, 5, 8'h55);
        settle();
        chk("bad5_error_count", 32'(bus.error_count), 1);
        chk("bad5_err_code", 32'(bus.err_code), 1);
        chk("bad5_byte_count", 32'(bus.byte_count), 32'h20);
        chk("bad5_pass", 32'(bus.pass), 0);

        // 0xFF: never a row break.
        arm_with(8'hFF);
        send_range(0, 255, 0, -1, 8'h00);
        settle();
        chk("fff_pass", 32'(bus.pass), 1);
        chk("fff_byte_count", 32'(bus.byte_count), 32'hFF);

        // Arm and rx_valid together in idle: the byte must be dropped.
        num = 8'h01;
        tick(1'b0, 1'b1, 1'b1, 8'h00);
        send(8'h00); send(8'h0D); send(8'h0A);
        settle();
        chk("armvalid_pass", 32'(bus.pass), 1);
        chk("armvalid_byte_count", 32'(bus.byte_count), 1);

        // Arm while busy must not restart the capture.
        d0 = done_cnt;
        arm_with(8'h20);
        send_range(0, 2, 32, -1, 8'h00);
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        send_range(2, 32, 32, -1, 8'h00);
        settle();
        chk("rearm_pass", 32'(bus.pass), 1);
        chk("rearm_byte_count", 32'(bus.byte_count), 32'h20);
        chk("rearm_done_pulses", 32'(done_cnt - d0), 1);

        // Stall after three bytes.
        arm_with(8'h20);
        send(8'h00); send(8'h20); send(8'h01);
        got = 1'b0;
        for (int k = 0; k < int'(LIMIT) + 20; k++) begin
            tick(1'b0, 1'b0, 1'b0, 8'h00);
            if (bus.done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("timeout_done_seen", 32'(got), 1);
        settle();
        chk("timeout_err_code", 32'(bus.err_code), 3);
        chk("timeout_byte_count", 32'(bus.byte_count), 2);
        chk("timeout_error_count", 32'(bus.error_count), 1);
        chk("timeout_pass", 32'(bus.pass), 0);
        chk("timeout_busy", 32'(bus.busy), 0);

        // Reset in the middle of a capture.
        arm_with(8'h20);
        send(8'h00); send(8'h20); send(8'h01);
        d0 = done_cnt;
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_byte_count", 32'(bus.byte_count), 0);
        chk("rst_led", 32'(bus.led), 0);
        settle();
        chk("rst_no_done", 32'(done_cnt - d0), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
